// File: rtl/dst_writeback_pkg.sv
// Shared constants for the destination write-back path: widths, opcodes,
// destination classes, SPRF indices and the FSM state type.
package dst_writeback_pkg;

  localparam int DST_W       = 9;
  localparam int OPR_W       = 5;
  localparam int DMEMADDRW   = 6;
  localparam int DATA_W      = 64;
  localparam int ALU_TIMEOUT = 255;

  localparam int IDX_W = DST_W - 3;
  localparam int CNT_W = $clog2(ALU_TIMEOUT + 1);

  localparam logic [OPR_W-1:0] OP_MOV = 5'd1;
  localparam logic [OPR_W-1:0] OP_JMP = 5'd16;
  localparam logic [OPR_W-1:0] OP_JRE = 5'd17;

  localparam logic [2:0] CLS_GPR     = 3'b000;
  localparam logic [2:0] CLS_RAM     = 3'b001;
  localparam logic [2:0] CLS_RMOD    = 3'b100;
  localparam logic [2:0] CLS_RAM_IND = 3'b101;

  localparam logic [IDX_W-1:0] IDX_SPRF0 = 6'd32;
  localparam logic [IDX_W-1:0] IDX_SPRF1 = 6'd33;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_ALU,
    ST_WRITE,
    ST_REDIRECT
  } wb_state_e;

  function automatic logic is_alu_op(input logic [OPR_W-1:0] op);
    return op inside {5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12};
  endfunction

endpackage

// File: rtl/dst_writeback_if.sv
// Issue-stage handshake carrying one (opcode, destination) pair plus the
// operands that must be captured at accept time.
interface dst_writeback_if;
  import dst_writeback_pkg::*;

  logic              issue_valid;
  logic              issue_ready;
  logic [OPR_W-1:0]  opr_code;
  logic [DST_W-1:0]  dst_code;
  logic [DATA_W-1:0] mov_data;
  logic              jre_eq;

  modport master (
    output issue_valid, opr_code, dst_code, mov_data, jre_eq,
    input  issue_ready
  );

  modport slave (
    input  issue_valid, opr_code, dst_code, mov_data, jre_eq,
    output issue_ready
  );

endinterface

// File: rtl/dst_writeback_wb_target_dec.sv
// Combinational destination decoder: turns an opcode/destination pair into
// the write enables, RAM address and an illegal-destination flag.
module dst_writeback_wb_target_dec
  import dst_writeback_pkg::*;
(
  input  logic [OPR_W-1:0]     opr,
  input  logic [DST_W-1:0]     dst,
  input  logic [DMEMADDRW-1:0] sprf0_val,
  input  logic [DMEMADDRW-1:0] sprf1_val,
  output logic [7:0]           gprf_we,
  output logic                 rmod_we,
  output logic                 dram_we,
  output logic [DMEMADDRW-1:0] dram_addr,
  output logic                 illegal
);

  logic [2:0]       cls;
  logic [IDX_W-1:0] idx;
  logic             idx_is_gpr;

  assign cls        = dst[DST_W-1:DST_W-3];
  assign idx        = dst[IDX_W-1:0];
  assign idx_is_gpr = (idx[IDX_W-1:3] == '0);

  // Only MOV looks at the class; ALU results always target the GPRF.
  always_comb begin
    gprf_we   = '0;
    rmod_we   = 1'b0;
    dram_we   = 1'b0;
    dram_addr = '0;
    illegal   = 1'b0;
    if (opr == OP_MOV) begin
      case (cls)
        CLS_GPR: begin
          if (idx_is_gpr) gprf_we[idx[2:0]] = 1'b1;
          else            illegal = 1'b1;
        end
        CLS_RAM: begin
          dram_we   = 1'b1;
          dram_addr = idx[DMEMADDRW-1:0];
        end
        CLS_RMOD: rmod_we = 1'b1;
        CLS_RAM_IND: begin
          if (idx == IDX_SPRF0) begin
            dram_we   = 1'b1;
            dram_addr = sprf0_val;
          end else if (idx == IDX_SPRF1) begin
            dram_we   = 1'b1;
            dram_addr = sprf1_val;
          end else begin
            illegal = 1'b1;
          end
        end
        default: illegal = 1'b1;
      endcase
    end else begin
      if (idx_is_gpr) gprf_we[idx[2:0]] = 1'b1;
      else            illegal = 1'b1;
    end
  end

endmodule

// File: rtl/dst_writeback.sv
// Destination write-back FSM: accepts issued instructions, waits for the ALU
// under a watchdog, then drives one cycle of write strobes or a PC redirect.
module dst_writeback
  import dst_writeback_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  dst_writeback_if.slave       issue,
  input  logic                 alu_done,
  input  logic [DATA_W-1:0]    alu_result,
  input  logic [DMEMADDRW-1:0] sprf0_val,
  input  logic [DMEMADDRW-1:0] sprf1_val,
  output logic [7:0]           gprf_we,
  output logic                 rmod_we,
  output logic [DATA_W-1:0]    wb_data,
  output logic                 dram_en_b,
  output logic                 dram_rw,
  output logic [DMEMADDRW-1:0] dram_addr,
  output logic                 pc_redirect,
  output logic [DST_W-1:0]     pc_target,
  output logic                 err_timeout,
  output logic                 err_dst
);

  wb_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [OPR_W-1:0]  opr_q, opr_d;
  logic [DST_W-1:0]  dst_q, dst_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              strobe_go, redirect_go, timeout_go;

  logic [7:0]           dec_gprf_we;
  logic                 dec_rmod_we;
  logic                 dec_dram_we;
  logic [DMEMADDRW-1:0] dec_dram_addr;
  logic                 dec_illegal;

  // Decoding the next-cycle opcode lets the strobes register on the edge
  // that enters WRITE, so they are visible for exactly the WRITE cycle.
  dst_writeback_wb_target_dec u_dec (
    .opr       (opr_d),
    .dst       (dst_d),
    .sprf0_val (sprf0_val),
    .sprf1_val (sprf1_val),
    .gprf_we   (dec_gprf_we),
    .rmod_we   (dec_rmod_we),
    .dram_we   (dec_dram_we),
    .dram_addr (dec_dram_addr),
    .illegal   (dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      opr_q   <= '0;
      dst_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opr_q   <= opr_d;
      dst_q   <= dst_d;
      data_q  <= data_d;
    end
  end

  // alu_done is checked before the watchdog so a result on the last allowed
  // cycle still gets written.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    opr_d       = opr_q;
    dst_d       = dst_q;
    data_d      = data_q;
    strobe_go   = 1'b0;
    redirect_go = 1'b0;
    timeout_go  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (issue.issue_valid) begin
          opr_d  = issue.opr_code;
          dst_d  = issue.dst_code;
          data_d = issue.mov_data;
          cnt_d  = '0;
          if (issue.opr_code == OP_MOV) begin
            state_d   = ST_WRITE;
            strobe_go = 1'b1;
          end else if (is_alu_op(issue.opr_code)) begin
            state_d = ST_WAIT_ALU;
          end else if ((issue.opr_code == OP_JMP) ||
                       ((issue.opr_code == OP_JRE) && issue.jre_eq)) begin
            state_d     = ST_REDIRECT;
            redirect_go = 1'b1;
          end
        end
      end
      ST_WAIT_ALU: begin
        if (alu_done) begin
          data_d    = alu_result;
          state_d   = ST_WRITE;
          strobe_go = 1'b1;
        end else if (cnt_q == CNT_W'(ALU_TIMEOUT)) begin
          state_d    = ST_IDLE;
          timeout_go = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gprf_we           <= '0;
      rmod_we           <= 1'b0;
      wb_data           <= '0;
      dram_en_b         <= 1'b1;
      dram_rw           <= 1'b1;
      dram_addr         <= '0;
      pc_redirect       <= 1'b0;
      pc_target         <= '0;
      err_timeout       <= 1'b0;
      err_dst           <= 1'b0;
      issue.issue_ready <= 1'b1;
    end else begin
      gprf_we           <= strobe_go ? dec_gprf_we : 8'h00;
      rmod_we           <= strobe_go & dec_rmod_we;
      dram_en_b         <= ~(strobe_go & dec_dram_we);
      dram_rw           <= ~(strobe_go & dec_dram_we);
      pc_redirect       <= redirect_go;
      issue.issue_ready <= (state_d == ST_IDLE);
      if (strobe_go) wb_data <= data_d;
      if (strobe_go && dec_dram_we) dram_addr <= dec_dram_addr;
      if (redirect_go) pc_target <= dst_d;
      if (timeout_go) err_timeout <= 1'b1;
      if (strobe_go && dec_illegal) err_dst <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dst_writeback.sv
// Self-checking bench for dst_writeback: directed cases plus randomized
// transactions compared against a transaction-level reference model.
module tb_dst_writeback;
  import dst_writeback_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dst_writeback_if issue_bus ();

  logic                 alu_done;
  logic [DATA_W-1:0]    alu_result;
  logic [DMEMADDRW-1:0] sprf0_val, sprf1_val;
  logic [7:0]           gprf_we;
  logic                 rmod_we;
  logic [DATA_W-1:0]    wb_data;
  logic                 dram_en_b, dram_rw;
  logic [DMEMADDRW-1:0] dram_addr;
  logic                 pc_redirect;
  logic [DST_W-1:0]     pc_target;
  logic                 err_timeout, err_dst;

  dst_writeback dut (
    .clk         (clk),
    .rst         (rst),
    .issue       (issue_bus),
    .alu_done    (alu_done),
    .alu_result  (alu_result),
    .sprf0_val   (sprf0_val),
    .sprf1_val   (sprf1_val),
    .gprf_we     (gprf_we),
    .rmod_we     (rmod_we),
    .wb_data     (wb_data),
    .dram_en_b   (dram_en_b),
    .dram_rw     (dram_rw),
    .dram_addr   (dram_addr),
    .pc_redirect (pc_redirect),
    .pc_target   (pc_target),
    .err_timeout (err_timeout),
    .err_dst     (err_dst)
  );

  int   checks = 0;
  int   failures = 0;
  logic exp_err_to = 1'b0;
  logic exp_err_dst = 1'b0;
  int   alu_ops[10] = '{2, 3, 4, 5, 6, 8, 9, 10, 11, 12};
  int   junk_ops[8] = '{0, 7, 13, 14, 15, 18, 25, 31};

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Strobes and flags are checked every cycle; data fields only when they matter.
  task automatic checkOutput(input string tag, input logic [7:0] eg, input logic er,
                             input logic ed, input logic [5:0] ea, input logic ew,
                             input logic [63:0] edat, input logic ep,
                             input logic [8:0] et, input logic erdy);
    checkVal($sformatf("%s.ctrl", tag),
             64'({gprf_we, rmod_we, dram_en_b, dram_rw, pc_redirect,
                  issue_bus.issue_ready, err_timeout, err_dst}),
             64'({eg, er, ~ed, ~ed, ep, erdy, exp_err_to, exp_err_dst}));
    if (ew) checkVal($sformatf("%s.wb_data", tag), wb_data, edat);
    if (ed) checkVal($sformatf("%s.dram_addr", tag), 64'(dram_addr), 64'(ea));
    if (ep) checkVal($sformatf("%s.pc_target", tag), 64'(pc_target), 64'(et));
  endtask

  task automatic checkQuiet(input string tag, input logic erdy);
    checkOutput(tag, 8'h00, 1'b0, 1'b0, 6'd0, 1'b0, 64'd0, 1'b0, 9'd0, erdy);
  endtask

  task automatic checkResetValues(input string tag);
    checkQuiet(tag, 1'b1);
    checkVal($sformatf("%s.wb_data0", tag), wb_data, 64'd0);
    checkVal($sformatf("%s.dram_addr0", tag), 64'(dram_addr), 64'd0);
    checkVal($sformatf("%s.pc_target0", tag), 64'(pc_target), 64'd0);
  endtask

  function automatic bit benchIsAlu(input logic [4:0] op);
    foreach (alu_ops[i]) if (5'(alu_ops[i]) == op) return 1'b1;
    return 1'b0;
  endfunction

  // Reference rules for where a completed instruction writes.
  task automatic modelWrite(input logic [4:0] opr, input logic [8:0] dst,
                            output logic [7:0] g, output logic r, output logic d,
                            output logic [5:0] a, output logic ill);
    int cls, idx;
    cls = int'(dst[8:6]);
    idx = int'(dst[5:0]);
    g = 8'h00; r = 1'b0; d = 1'b0; a = 6'd0; ill = 1'b0;
    if (opr == 5'd1) begin
      if (cls == 0 && idx < 8) g = 8'(1 << idx);
      else if (cls == 1) begin d = 1'b1; a = 6'(idx); end
      else if (cls == 4) r = 1'b1;
      else if (cls == 5 && idx == 32) begin d = 1'b1; a = sprf0_val; end
      else if (cls == 5 && idx == 33) begin d = 1'b1; a = sprf1_val; end
      else ill = 1'b1;
    end else begin
      if (idx < 8) g = 8'(1 << idx);
      else ill = 1'b1;
    end
  endtask

  // Entered and left at a negedge with the DUT idle.
  task automatic applyStimulus(input string tag, input logic [4:0] opr, input logic [8:0] dst,
                               input logic [63:0] data, input logic jre, input int delay,
                               input logic [63:0] res);
    logic [7:0] g;
    logic       r, d, ill;
    logic [5:0] a;
    checkQuiet({tag, ".pre"}, 1'b1);
    issue_bus.issue_valid = 1'b1;
    issue_bus.opr_code    = opr;
    issue_bus.dst_code    = dst;
    issue_bus.mov_data    = data;
    issue_bus.jre_eq      = jre;
    @(negedge clk);
    issue_bus.issue_valid = 1'b0;
    issue_bus.opr_code    = 5'($urandom);
    issue_bus.dst_code    = 9'($urandom);
    issue_bus.mov_data    = {$urandom, $urandom};
    issue_bus.jre_eq      = 1'($urandom);
    if (opr == 5'd1 || benchIsAlu(opr)) begin
      if (benchIsAlu(opr)) begin
        for (int i = 0; i < delay; i++) begin
          checkQuiet({tag, ".wait"}, 1'b0);
          @(negedge clk);
        end
        checkQuiet({tag, ".done"}, 1'b0);
        alu_done   = 1'b1;
        alu_result = res;
        @(negedge clk);
        alu_done   = 1'b0;
        alu_result = {$urandom, $urandom};
      end
      modelWrite(opr, dst, g, r, d, a, ill);
      if (ill) exp_err_dst = 1'b1;
      checkOutput({tag, ".write"}, g, r, d, a, !ill, benchIsAlu(opr) ? res : data,
                  1'b0, 9'd0, 1'b0);
      @(negedge clk);
    end else if (opr == 5'd16 || (opr == 5'd17 && jre)) begin
      checkOutput({tag, ".redir"}, 8'h00, 1'b0, 1'b0, 6'd0, 1'b0, 64'd0, 1'b1, dst, 1'b0);
      @(negedge clk);
    end
    checkQuiet({tag, ".post"}, 1'b1);
  endtask

  initial begin
    logic [4:0]  opr;
    logic [2:0]  cls;
    logic [5:0]  idx;
    issue_bus.issue_valid = 1'b0;
    issue_bus.opr_code    = '0;
    issue_bus.dst_code    = '0;
    issue_bus.mov_data    = '0;
    issue_bus.jre_eq      = 1'b0;
    alu_done   = 1'b0;
    alu_result = '0;
    sprf0_val  = 6'h11;
    sprf1_val  = 6'h2C;

    repeat (3) @(negedge clk);
    checkResetValues("reset");
    rst = 1'b0;
    @(negedge clk);

    applyStimulus("mov_gpr5", 5'd1, {3'b000, 6'd5}, 64'hA5, 1'b0, 0, 64'd0);
    applyStimulus("mov_ram", 5'd1, {3'b001, 6'd41}, 64'hDEAD_BEEF, 1'b0, 0, 64'd0);
    applyStimulus("mov_rmod", 5'd1, {3'b100, 6'd7}, 64'h77, 1'b0, 0, 64'd0);
    applyStimulus("mov_ind32", 5'd1, {3'b101, 6'd32}, 64'h5A5A, 1'b0, 0, 64'd0);
    applyStimulus("mov_ind33", 5'd1, {3'b101, 6'd33}, 64'hC3C3, 1'b0, 0, 64'd0);
    applyStimulus("alu4_idx2", 5'd4, {3'b000, 6'd2}, 64'h9999, 1'b0, 7, 64'h1234);
    applyStimulus("alu2_cls6", 5'd2, {3'b110, 6'd7}, 64'h0, 1'b0, 0, 64'hFEED);
    applyStimulus("jmp", 5'd16, 9'h1F3, 64'h0, 1'b0, 0, 64'd0);
    applyStimulus("jre_ne", 5'd17, 9'h0AA, 64'h0, 1'b0, 0, 64'd0);
    applyStimulus("jre_eq", 5'd17, 9'h055, 64'h0, 1'b1, 0, 64'd0);
    applyStimulus("junk_op", 5'd7, {3'b000, 6'd1}, 64'h1, 1'b0, 0, 64'd0);

    alu_done = 1'b1;
    @(negedge clk);
    alu_done = 1'b0;
    checkQuiet("alu_done_idle", 1'b1);

    applyStimulus("mov_ind34", 5'd1, {3'b101, 6'd34}, 64'h1, 1'b0, 0, 64'd0);
    applyStimulus("mov_cls2", 5'd1, {3'b010, 6'd3}, 64'h2, 1'b0, 0, 64'd0);

    for (int n = 0; n < 40; n++) begin
      sprf0_val = 6'($urandom);
      sprf1_val = 6'($urandom);
      case ($urandom_range(0, 9))
        0, 1, 2, 3: opr = 5'd1;
        4, 5, 6:    opr = 5'(alu_ops[$urandom_range(0, 9)]);
        7:          opr = 5'd16;
        8:          opr = 5'd17;
        default:    opr = 5'(junk_ops[$urandom_range(0, 7)]);
      endcase
      cls = 3'($urandom);
      if ($urandom_range(0, 3) == 0) idx = 6'($urandom);
      else if (cls == 3'b101)        idx = 6'(32 + $urandom_range(0, 1));
      else                           idx = 6'($urandom_range(0, 7));
      applyStimulus($sformatf("rnd%0d", n), opr, {cls, idx}, {$urandom, $urandom},
                    1'($urandom), $urandom_range(0, 20), {$urandom, $urandom});
    end

    applyStimulus("alu_at_expiry", 5'd9, {3'b111, 6'd6}, 64'h0, 1'b0, ALU_TIMEOUT, 64'hABCD);

    checkQuiet("timeout.pre", 1'b1);
    issue_bus.issue_valid = 1'b1;
    issue_bus.opr_code    = 5'd3;
    issue_bus.dst_code    = {3'b000, 6'd1};
    @(negedge clk);
    issue_bus.issue_valid = 1'b0;
    for (int k = 0; k <= ALU_TIMEOUT; k++) begin
      checkQuiet("timeout.wait", 1'b0);
      @(negedge clk);
    end
    exp_err_to = 1'b1;
    checkQuiet("timeout.expired", 1'b1);
    @(negedge clk);
    checkQuiet("timeout.idle", 1'b1);

    issue_bus.issue_valid = 1'b1;
    issue_bus.opr_code    = 5'd4;
    issue_bus.dst_code    = {3'b000, 6'd2};
    @(negedge clk);
    issue_bus.issue_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst        = 1'b0;
    alu_done   = 1'b1;
    alu_result = 64'h4321;
    @(negedge clk);
    alu_done    = 1'b0;
    exp_err_to  = 1'b0;
    exp_err_dst = 1'b0;
    checkResetValues("rst_midop");
    @(negedge clk);
    checkResetValues("rst_midop.after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
